fht_io_sequencer: RTL and testbench



---
 rtl/fht_io_sequencer_if.sv | 42 ++++
 rtl/fht_io_sequencer.sv | 132 +++++++++++++
 tb/tb_fht_io_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fht_io_sequencer_if.sv
// Bundle of stream, bank-write, bank-read and debug signals between the FHT I/O
// sequencer and its surroundings; the sequencer binds the master modport.
interface fht_io_sequencer_if #(
  parameter int D_BIT = 22,
  parameter int A_BIT = 9
);
  // Valid/ready: a word transfers on a rising edge where valid and ready are both
  // high; the source holds valid and data stable until then, ready may toggle freely.
  logic                    iS_VALID;
  logic [D_BIT-2:0]        iS_DATA;
  logic                    oS_READY;
  logic [3:0]              oWE;
  logic [D_BIT-2:0]        oDATA;
  logic [A_BIT-1:0]        oADDR_WR;
  logic                    oSTART;
  logic                    iFHT_RDY;
  logic [A_BIT-1:0]        oADDR_RD;
  logic signed [D_BIT-1:0] iFHT_DATA_0;
  logic signed [D_BIT-1:0] iFHT_DATA_1;
  logic signed [D_BIT-1:0] iFHT_DATA_2;
  logic signed [D_BIT-1:0] iFHT_DATA_3;
  logic                    oM_VALID;
  logic signed [D_BIT-1:0] oM_DATA;
  logic                    oM_LAST;
  logic                    iM_READY;
  logic                    oBUSY;
  logic [2:0]              oSTATE;

  modport master (
    input  iS_VALID, iS_DATA, iFHT_RDY, iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2,
           iFHT_DATA_3, iM_READY,
    output oS_READY, oWE, oDATA, oADDR_WR, oSTART, oADDR_RD, oM_VALID, oM_DATA,
           oM_LAST, oBUSY, oSTATE
  );

  modport slave (
    output iS_VALID, iS_DATA, iFHT_RDY, iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2,
           iFHT_DATA_3, iM_READY,
    input  oS_READY, oWE, oDATA, oADDR_WR, oSTART, oADDR_RD, oM_VALID, oM_DATA,
           oM_LAST, oBUSY, oSTATE
  );
endinterface

// File: rtl/fht_io_sequencer.sv
// Frame scheduler for the 4-bank FHT: scatters a sample stream over the banks,
// kicks the transform, then reads the banks back and re-serialises the spectrum.
module fht_io_sequencer #(
  parameter int D_BIT  = 22,
  parameter int A_BIT  = 9,
  parameter int RD_LAT = 2
) (
  input logic iCLK,
  input logic iRESET,
  fht_io_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  localparam logic [A_BIT+1:0] N_LAST    = '1;
  localparam logic [A_BIT-1:0] A_LAST    = '1;
  localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 2);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [A_BIT+1:0]        r_n;
  logic                    r_flush;
  logic [3:0]              r_we;
  logic [D_BIT-2:0]        r_data;
  logic [A_BIT-1:0]        r_addr_wr;
  logic [A_BIT-1:0]        r_a;
  logic                    r_rdy_d;
  logic [1:0]              r_wait;
  logic [1:0]              r_k;
  logic signed [D_BIT-1:0] r_hold [4];

  logic w_hs_in;
  logic w_hs_out;
  logic w_n_last;
  logic w_a_last;
  logic w_k_last;
  logic w_rdy_rise;
  logic w_wait_done;
  logic w_capture;

  // r_flush marks the cycle that presents the final bank write; ready is already low.
  assign w_hs_in     = (r_state == S_LOAD) && !r_flush && bus.iS_VALID;
  assign w_hs_out    = (r_state == S_SEND) && bus.iM_READY;
  assign w_n_last    = (r_n == N_LAST);
  assign w_a_last    = (r_a == A_LAST);
  assign w_k_last    = (r_k == 2'd3);
  assign w_rdy_rise  = bus.iFHT_RDY && !r_rdy_d;
  assign w_wait_done = (RD_LAT <= 1) || (r_wait == WAIT_LAST);
  // With RD_LAT = 1 the data is captured at the end of RD_ADDR and RD_WAIT is skipped.
  assign w_capture   = ((r_state == S_RD_ADDR) && (RD_LAT <= 1)) ||
                       ((r_state == S_RD_WAIT) && w_wait_done);

  always_ff @(posedge iCLK) begin
    if (iRESET) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (r_flush) w_state_nxt = S_START;
      S_START:   w_state_nxt = S_WAIT;
      S_WAIT:    if (w_rdy_rise) w_state_nxt = S_RD_ADDR;
      S_RD_ADDR: w_state_nxt = (RD_LAT <= 1) ? S_SEND : S_RD_WAIT;
      S_RD_WAIT: if (w_wait_done) w_state_nxt = S_SEND;
      S_SEND:    if (w_hs_out && w_k_last) w_state_nxt = w_a_last ? S_LOAD : S_RD_ADDR;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    bus.oS_READY = (r_state == S_LOAD) && !r_flush;
    bus.oSTART   = (r_state == S_START);
    bus.oM_VALID = (r_state == S_SEND);
    bus.oM_LAST  = (r_state == S_SEND) && w_k_last && w_a_last;
    bus.oBUSY    = (r_state != S_LOAD);
  end

  assign bus.oWE      = r_we;
  assign bus.oDATA    = r_data;
  assign bus.oADDR_WR = r_addr_wr;
  assign bus.oADDR_RD = r_a;
  assign bus.oM_DATA  = r_hold[r_k];
  assign bus.oSTATE   = r_state;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_n       <= '0;
      r_flush   <= 1'b0;
      r_we      <= '0;
      r_data    <= '0;
      r_addr_wr <= '0;
      r_a       <= '0;
      r_rdy_d   <= 1'b0;
      r_wait    <= '0;
      r_k       <= '0;
      for (int i = 0; i < 4; i++) r_hold[i] <= '0;
    end else begin
      r_rdy_d <= bus.iFHT_RDY;
      r_we    <= '0;
      if (w_hs_in) begin
        r_we      <= 4'b0001 << r_n[1:0];
        r_data    <= bus.iS_DATA;
        r_addr_wr <= r_n[A_BIT+1:2];
        r_n       <= w_n_last ? '0 : r_n + 1'b1;
        r_flush   <= w_n_last;
      end else if ((r_state == S_LOAD) && r_flush) begin
        r_flush <= 1'b0;
      end
      // The read address is both the bank address and the frame read counter.
      if ((r_state == S_WAIT) && w_rdy_rise) r_a <= '0;
      if (r_state == S_RD_WAIT) r_wait <= r_wait + 1'b1;
      else                      r_wait <= '0;
      if (w_capture) begin
        r_hold[0] <= bus.iFHT_DATA_0;
        r_hold[1] <= bus.iFHT_DATA_1;
        r_hold[2] <= bus.iFHT_DATA_2;
        r_hold[3] <= bus.iFHT_DATA_3;
      end
      if (w_hs_out) begin
        r_k <= w_k_last ? 2'd0 : r_k + 1'b1;
        if (w_k_last && !w_a_last) r_a <= r_a + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fht_io_sequencer.sv
// Directed bench for fht_io_sequencer: two instances (RD_LAT 2 and 4) share the
// stimulus; each sees its own bank model keyed on its own read address.
module tb_fht_io_sequencer;
  localparam int DB = 22;
  localparam int AB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fht_io_sequencer_if #(.D_BIT(DB), .A_BIT(AB)) b2 ();
  fht_io_sequencer_if #(.D_BIT(DB), .A_BIT(AB)) b4 ();

  fht_io_sequencer #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(2)) u_dut2 (
    .iCLK(clk), .iRESET(rst), .bus(b2)
  );
  fht_io_sequencer #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(4)) u_dut4 (
    .iCLK(clk), .iRESET(rst), .bus(b4)
  );

  assign b4.iS_VALID = b2.iS_VALID;
  assign b4.iS_DATA  = b2.iS_DATA;
  assign b4.iFHT_RDY = b2.iFHT_RDY;
  assign b4.iM_READY = b2.iM_READY;

  // Bank models: bank k at address a returns 100+4a+k, valid RD_LAT cycles after the address.
  logic [AB-1:0] q2, q4a, q4b, q4c;
  always @(posedge clk) begin
    q2  <= b2.oADDR_RD;
    q4a <= b4.oADDR_RD;
    q4b <= q4a;
    q4c <= q4b;
  end
  assign b2.iFHT_DATA_0 = DB'(100 + 4 * int'(q2) + 0);
  assign b2.iFHT_DATA_1 = DB'(100 + 4 * int'(q2) + 1);
  assign b2.iFHT_DATA_2 = DB'(100 + 4 * int'(q2) + 2);
  assign b2.iFHT_DATA_3 = DB'(100 + 4 * int'(q2) + 3);
  assign b4.iFHT_DATA_0 = DB'(100 + 4 * int'(q4c) + 0);
  assign b4.iFHT_DATA_1 = DB'(100 + 4 * int'(q4c) + 1);
  assign b4.iFHT_DATA_2 = DB'(100 + 4 * int'(q4c) + 2);
  assign b4.iFHT_DATA_3 = DB'(100 + 4 * int'(q4c) + 3);

  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] got2[$], got4[$];
  logic          last2[$], last4[$];
  logic [26:0]   wr_q[$];
  int            wr_t[$];
  int            start_t[$];
  int            first2, lastt2, first4, lastt4;
  logic          prev_stall2 = 1'b0, prev_stall4 = 1'b0;
  logic [DB-1:0] prev_d2, prev_d4;
  int            stall_err = 0, stall_seen = 0;
  logic [26:0]   e_wr;
  int            last_wr;

  always @(negedge clk) begin
    if (b2.oM_VALID && b2.iM_READY) begin
      if (got2.size() == 0) first2 = cyc;
      lastt2 = cyc;
      got2.push_back(b2.oM_DATA);
      last2.push_back(b2.oM_LAST);
    end
    if (b4.oM_VALID && b4.iM_READY) begin
      if (got4.size() == 0) first4 = cyc;
      lastt4 = cyc;
      got4.push_back(b4.oM_DATA);
      last4.push_back(b4.oM_LAST);
    end
    if (b2.oWE != 4'd0) begin
      wr_q.push_back({b2.oWE, b2.oADDR_WR, b2.oDATA});
      wr_t.push_back(cyc);
    end
    if (b2.oSTART) start_t.push_back(cyc);
    if (prev_stall2 && (b2.oM_VALID !== 1'b1 || b2.oM_DATA !== prev_d2)) stall_err++;
    if (prev_stall4 && (b4.oM_VALID !== 1'b1 || b4.oM_DATA !== prev_d4)) stall_err++;
    if (b2.oM_VALID && !b2.iM_READY) stall_seen++;
    prev_stall2 = b2.oM_VALID && !b2.iM_READY;
    prev_stall4 = b4.oM_VALID && !b4.iM_READY;
    prev_d2     = b2.oM_DATA;
    prev_d4     = b4.oM_DATA;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string p);
    check({p, "_s_ready"}, b2.oS_READY, 1);
    check({p, "_we"},      b2.oWE, 0);
    check({p, "_data"},    b2.oDATA, 0);
    check({p, "_addr_wr"}, b2.oADDR_WR, 0);
    check({p, "_start"},   b2.oSTART, 0);
    check({p, "_addr_rd"}, b2.oADDR_RD, 0);
    check({p, "_m_valid"}, b2.oM_VALID, 0);
    check({p, "_m_data"},  b2.oM_DATA, 0);
    check({p, "_m_last"},  b2.oM_LAST, 0);
    check({p, "_busy"},    b2.oBUSY, 0);
    check({p, "_ready4"},  b4.oS_READY, 1);
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      b2.iS_DATA  = 21'(base + i);
      b2.iS_VALID = 1'b1;
      step();
    end
  endtask

  task automatic readback(input bit toggle, input string p);
    bit done;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(DB'(100 + i));
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (toggle) b2.iM_READY = ~b2.iM_READY;
      step();
      done = (got2.size() >= 16) && (got4.size() >= 16) &&
             (b2.oSTATE == 3'd0) && (b4.oSTATE == 3'd0);
    end
    check({p, "_timeout"}, done, 1);
    check({p, "_cnt2"}, got2.size(), 16);
    check({p, "_cnt4"}, got4.size(), 16);
    for (int i = 0; i < 16 && i < got2.size(); i++) begin
      check({p, "_data2"}, got2[i], exp_q[i]);
      check({p, "_last2"}, last2[i], (i == 15) ? 1 : 0);
    end
    for (int i = 0; i < 16 && i < got4.size(); i++) begin
      check({p, "_data4"}, got4[i], exp_q[i]);
      check({p, "_last4"}, last4[i], (i == 15) ? 1 : 0);
    end
    check({p, "_ready2_after"}, b2.oS_READY, 1);
    check({p, "_ready4_after"}, b4.oS_READY, 1);
  endtask

  initial begin
    b2.iS_VALID = 1'b0;
    b2.iS_DATA  = '0;
    b2.iFHT_RDY = 1'b0;
    b2.iM_READY = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_idle("rst");
    rst = 1'b0;

    // Partial frame of 7 samples, then reset mid-frame.
    for (int i = 0; i < 7; i++) begin
      b2.iS_DATA  = 21'(200 + i);
      b2.iS_VALID = 1'b1;
      step();
    end
    check("part_we", b2.oWE, 4'b0100);
    check("part_addr", b2.oADDR_WR, 1);
    b2.iS_VALID = 1'b0;
    rst = 1'b1;
    step();
    check_idle("midrst");
    rst = 1'b0;
    wr_q.delete();
    wr_t.delete();
    start_t.delete();

    // Frame 1: FHT ready held high from before START.
    b2.iFHT_RDY = 1'b1;
    load_frame(0);
    check("ready_drop", b2.oS_READY, 0);
    check("last_we", b2.oWE, 4'b1000);
    step();
    check("start_pulse", b2.oSTART, 1);
    check("start_busy", b2.oBUSY, 1);
    step();
    check("start_once", b2.oSTART, 0);
    step();
    step();
    check("wait_state", b2.oSTATE, 2);
    check("busy_ready", b2.oS_READY, 0);
    b2.iS_VALID = 1'b0;
    check("wr_cnt", wr_q.size(), 16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      e_wr = {4'(1 << (i % 4)), 2'(i / 4), 21'(i)};
      check("wr_entry", wr_q[i], e_wr);
      check("wr_time", wr_t[i], wr_t[0] + i);
    end
    last_wr = (wr_t.size() > 0) ? wr_t[wr_t.size() - 1] : -100;
    check("start_cnt", start_t.size(), 1);
    if (start_t.size() > 0) check("start_time", start_t[0], last_wr + 1);

    b2.iM_READY = 1'b1;
    b2.iFHT_RDY = 1'b0;
    repeat (10) step();
    check("no_read_early", got2.size() + got4.size(), 0);
    check("still_wait", b2.oSTATE, 2);
    b2.iFHT_RDY = 1'b1;
    step();
    check("rd_addr_state", b2.oSTATE, 3);
    check("rd_addr0", b2.oADDR_RD, 0);
    readback(1'b0, "rb1");
    check("tput2", (lastt2 - first2) <= 24, 1);
    check("tput4", (lastt4 - first4) <= 30, 1);

    // Frame 2: backpressure toggling every cycle.
    got2.delete(); got4.delete(); last2.delete(); last4.delete();
    wr_q.delete(); wr_t.delete();
    load_frame(16);
    b2.iS_VALID = 1'b0;
    step();
    step();
    b2.iFHT_RDY = 1'b0;
    step();
    step();
    check("f2_wait", b2.oSTATE, 2);
    check("f2_addr_held", b2.oADDR_RD, 3);
    check("f2_wr_cnt", wr_q.size(), 16);
    b2.iFHT_RDY = 1'b1;
    step();
    check("f2_rd_addr0", b2.oADDR_RD, 0);
    b2.iM_READY = 1'b0;
    readback(1'b1, "rb2");
    check("stall_stable", stall_err, 0);
    check("stall_seen", stall_seen > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
